regfile_seq_ctrl: RTL and testbench
===================================

Name: regfile_seq_ctrl

Overview:
- Multi-cycle controller that sequences the 4x8-bit register file (2-bit selA/selB, WE, dataW; combinational reads, write on posedge to the register addressed by selA).
- Accepts one 16-bit instruction per valid/ready handshake, reads operands, executes in an internal ALU, writes back, then reports done.
- Sits between the instruction source and the register file; it is the only master of the regfile write port.

Parameters:
- DATA_W, 8, datapath width. Must equal the regfile width; only 8 is verified.

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  instruction valid
- in_instr  in  16  instruction word
- in_ready  out  1  controller can accept an instruction
- rf_we  out  1  to regfile WE
- rf_selA  out  2  to regfile selA; also the write address
- rf_selB  out  2  to regfile selB
- rf_dataW  out  DATA_W  to regfile dataW
- rf_dataA  in  DATA_W  from regfile dataA
- rf_dataB  in  DATA_W  from regfile dataB
- done  out  1  one-cycle pulse when an instruction retires
- halted  out  1  HALT executed; sticky until reset
- flags  out  3  {N,Z,C} from the last ALU op

Behaviour:
- Instruction fields: op=[15:13], rd=[12:11], rs=[10:9], rt=[8:7], imm8=[7:0]. rt and imm8 overlap; the op decides which is used.
- Ops:
  - 000 NOP
  - 001 MOVI: rd<=imm8
  - 010 MOV: rd<=rs
  - 011 ADD: rd<=rs+rt
  - 100 SUB: rd<=rs-rt
  - 101 AND: rd<=rs&rt
  - 110 NOT: rd<=~rs
  - 111 HALT
- States: IDLE, DECODE, READ, EXEC, WRITE, HALTED.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_instr and go to DECODE. No latch otherwise.
- DECODE:
  - NOP: done=1 this cycle, next state IDLE.
  - HALT: next state HALTED.
  - MOVI: next state WRITE.
  - All other ops: next state READ.
- READ:
  - rf_selA=rs, rf_selB=rt.
  - Latch rf_dataA into opA and rf_dataB into opB at the end of the cycle.
  - Next state EXEC.
- EXEC:
  - Compute the result into a register.
  - Update flags: N=result[7], Z=(result==0).
  - C: ADD carry-out; SUB = 1 when no borrow (rs>=rt unsigned); MOV/AND/NOT clear C.
  - Next state WRITE.
- WRITE:
  - rf_we=1, rf_selA=rd, rf_dataW=result (imm8 for MOVI), done=1.
  - Next state IDLE.
  - MOVI does not change flags.
- HALTED:
  - halted=1, in_ready=0.
  - The only exit is reset.
- Latency, counted from the cycle of the accepting edge:
  - ALU ops: rf_we/done asserted 4 cycles later (DECODE, READ, EXEC, WRITE).
  - MOVI: 2 cycles later.
  - NOP: done 1 cycle later.
- Throughput: in_ready is 0 from DECODE through WRITE, so only one instruction is ever in flight. A new instruction can be accepted in the cycle after WRITE.
- rf_we is 1 only in WRITE. In all other states rf_we=0 and rf_dataW=0.
- rf_selA/rf_selB are 0 outside READ/WRITE; rf_selA=rd in WRITE.
- All arithmetic is modulo 2^8. Results are truncated to 8 bits; C carries the 9th bit.
- Reset (rst_n=0 at posedge), including mid-operation:
  - State goes to IDLE; latched instruction, opA, opB, result, flags and halted are cleared.
  - rf_we, done, in_ready and rf_sel* are all 0 while rst_n=0.
  - rf_we must be 0 during reset, because the regfile only clears when WE is low.
  - An in-flight write is dropped, never partially performed.
- in_instr changing while the controller is busy has no effect.
- in_valid held high in IDLE causes back-to-back acceptance, one instruction per completion.
- rd==rs or rd==rt is legal: operands are latched in READ, before WRITE.

Test Plan:
- Reset, then MOVI R1,0x05; MOVI R2,0x03 -> rf_we pulses with selA=1/dataW=0x05, then selA=2/dataW=0x03; done=1 in each WRITE cycle; 2-cycle latency.
- ADD R3,R1,R2 after the above -> READ drives selA=1, selB=2; WRITE selA=3, dataW=0x08; flags N=0, Z=0, C=0; rf_we exactly 4 cycles after accept.
- MOVI R0,0xFF; MOVI R1,0x01; ADD R0,R0,R1 -> dataW=0x00, Z=1, C=1. Then SUB R2,R1,R0 (1-0) -> dataW=0x01, C=1. Then SUB R2,R0,R1 (0-1) -> dataW=0xFF, N=1, C=0.
- NOP -> done pulse 1 cycle after accept, rf_we never asserted, flags unchanged. HALT -> halted=1 and in_ready=0 forever; in_valid ignored until rst_n=0.
- rst_n=0 in the EXEC cycle of ADD R3,R1,R2 -> no rf_we, state IDLE, flags=0, in_ready=1 the cycle after rst_n returns high.
- in_valid held high with 3 queued MOVIs -> exactly 3 done pulses; in_ready=0 from DECODE to WRITE; no instruction lost or duplicated.

Source files
------------

// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl: multi-cycle controller driving a 4x8 register file through decode/read/exec/write.
module regfile_seq_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  output logic              in_ready,
  output logic              rf_we,
  output logic [1:0]        rf_selA,
  output logic [1:0]        rf_selB,
  output logic [DATA_W-1:0] rf_dataW,
  input  logic [DATA_W-1:0] rf_dataA,
  input  logic [DATA_W-1:0] rf_dataB,
  output logic              done,
  output logic              halted,
  output logic [2:0]        flags
);
  typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WRITE, HALTED} state_t;
  localparam logic [2:0] OP_NOP = 3'b000, OP_MOVI = 3'b001, OP_ADD = 3'b011,
                         OP_SUB = 3'b100, OP_AND = 3'b101, OP_NOT = 3'b110, OP_HALT = 3'b111;
  state_t state, state_nx;
  logic [15:0] instr;
  logic [DATA_W-1:0] op_a, op_b, result, alu_res;
  logic [DATA_W:0] sum, diff;
  logic alu_c;
  logic [2:0] op;
  logic [1:0] rd, rs, rt;
  assign op = instr[15:13];
  assign rd = instr[12:11];
  assign rs = instr[10:9];
  assign rt = instr[8:7];
  assign sum = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};
  // SUB carry is the inverted borrow, i.e. set when rs >= rt unsigned
  always_comb begin
    alu_res = op == OP_ADD ? sum[DATA_W-1:0] :
              op == OP_SUB ? diff[DATA_W-1:0] :
              op == OP_AND ? op_a & op_b :
              op == OP_NOT ? ~op_a : op_a;
    alu_c = op == OP_ADD ? sum[DATA_W] : op == OP_SUB ? ~diff[DATA_W] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      instr  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) instr <= in_instr;
      if (state == READ) begin
        op_a <= rf_dataA;
        op_b <= rf_dataB;
      end
      if (state == EXEC) begin
        result <= alu_res;
        flags  <= {alu_res[DATA_W-1], alu_res == '0, alu_c};
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? DECODE : IDLE;
      DECODE:  state_nx = op == OP_NOP ? IDLE : op == OP_HALT ? HALTED : op == OP_MOVI ? WRITE : READ;
      READ:    state_nx = EXEC;
      EXEC:    state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      HALTED:  state_nx = HALTED;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs are forced low while reset is asserted so the regfile sees WE=0 and clears
  always_comb begin
    in_ready = rst_n && state == IDLE;
    rf_we    = rst_n && state == WRITE;
    done     = rst_n && (state == WRITE || (state == DECODE && op == OP_NOP));
    halted   = rst_n && state == HALTED;
    rf_selA  = !rst_n ? 2'd0 : state == READ ? rs : state == WRITE ? rd : 2'd0;
    rf_selB  = rst_n && state == READ ? rt : 2'd0;
    rf_dataW = !rf_we ? '0 : op == OP_MOVI ? DATA_W'(instr[7:0]) : result;
  end
endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb_regfile_seq_ctrl: directed bench for regfile_seq_ctrl with a behavioural 4x8 register file attached.
module tb_regfile_seq_ctrl;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [15:0] in_instr = '0;
  logic in_ready, rf_we, done, halted;
  logic [1:0] rf_selA, rf_selB;
  logic [7:0] rf_dataW, rf_dataA, rf_dataB;
  logic [2:0] flags;
  logic [7:0] mem [4];
  int checks = 0, errors = 0;

  regfile_seq_ctrl #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .rf_we(rf_we), .rf_selA(rf_selA), .rf_selB(rf_selB), .rf_dataW(rf_dataW),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB), .done(done), .halted(halted), .flags(flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) mem[rf_selA] <= rf_dataW;
    else if (!rst_n) for (int i = 0; i < 4; i++) mem[i] <= '0;
  end
  assign rf_dataA = mem[rf_selA];
  assign rf_dataB = mem[rf_selB];

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
    return {op, rd, rs, rt, 7'b0};
  endfunction

  function automatic logic [15:0] mki(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b001, rd, 3'b000, imm};
  endfunction

  // Issues one instruction from an IDLE negedge and returns at the negedge after retirement.
  task automatic run(input string tag, input logic [15:0] ins, input int lat, input logic exp_we,
                     input logic [1:0] exp_sel, input logic [7:0] exp_data, input logic [2:0] exp_flags);
    in_valid = 1; in_instr = ins;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_idle got=%b exp=1", tag, in_ready); end
    @(negedge clk);
    in_valid = 0; in_instr = 16'hFFFF;
    for (int n = 1; n <= lat; n++) begin
      if (n > 1) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s ready_busy n=%0d got=%b exp=0", tag, n, in_ready); end
      checks++; if (done !== 1'(n == lat)) begin errors++; $display("FAIL %s done n=%0d got=%b exp=%b", tag, n, done, n == lat); end
      checks++; if (rf_we !== 1'(exp_we && n == lat)) begin errors++; $display("FAIL %s we n=%0d got=%b exp=%b", tag, n, rf_we, exp_we && n == lat); end
      if (lat == 4 && n == 2) begin
        checks++; if (rf_selA !== ins[10:9] || rf_selB !== ins[8:7]) begin errors++; $display("FAIL %s read_sel got=%0d/%0d exp=%0d/%0d", tag, rf_selA, rf_selB, ins[10:9], ins[8:7]); end
      end
      if (n == lat && exp_we) begin
        checks++; if (rf_selA !== exp_sel || rf_dataW !== exp_data) begin errors++; $display("FAIL %s write got=%0d/%h exp=%0d/%h", tag, rf_selA, rf_dataW, exp_sel, exp_data); end
      end
      if (!(n == lat && exp_we)) begin
        checks++; if (rf_dataW !== 8'h00) begin errors++; $display("FAIL %s dataw_idle n=%0d got=%h exp=00", tag, n, rf_dataW); end
      end
    end
    @(negedge clk);
    checks++; if (flags !== exp_flags) begin errors++; $display("FAIL %s flags got=%b exp=%b", tag, flags, exp_flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_after got=%b exp=1", tag, in_ready); end
  endtask

  task automatic test_reset;
    rst_n = 0; in_valid = 1; in_instr = mki(2'd1, 8'hAA);
    @(negedge clk); @(negedge clk);
    checks++; if ({in_ready, rf_we, done, halted} !== 4'b0) begin errors++; $display("FAIL reset outs got=%b exp=0000", {in_ready, rf_we, done, halted}); end
    checks++; if ({rf_selA, rf_selB, flags} !== 7'b0) begin errors++; $display("FAIL reset sel_flags got=%b exp=0", {rf_selA, rf_selB, flags}); end
    rst_n = 1; in_valid = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset ready_release got=%b exp=1", in_ready); end
  endtask

  task automatic test_movi;
    run("movi_r1", mki(2'd1, 8'h05), 2, 1'b1, 2'd1, 8'h05, 3'b000);
    run("movi_r2", mki(2'd2, 8'h03), 2, 1'b1, 2'd2, 8'h03, 3'b000);
  endtask

  task automatic test_add;
    run("add_r3", mk(3'b011, 2'd3, 2'd1, 2'd2), 4, 1'b1, 2'd3, 8'h08, 3'b000);
  endtask

  task automatic test_alu;
    run("movi_r0ff", mki(2'd0, 8'hFF), 2, 1'b1, 2'd0, 8'hFF, 3'b000);
    run("movi_r101", mki(2'd1, 8'h01), 2, 1'b1, 2'd1, 8'h01, 3'b000);
    run("add_wrap", mk(3'b011, 2'd0, 2'd0, 2'd1), 4, 1'b1, 2'd0, 8'h00, 3'b011);
    run("sub_nb", mk(3'b100, 2'd2, 2'd1, 2'd0), 4, 1'b1, 2'd2, 8'h01, 3'b001);
    run("mov", mk(3'b010, 2'd3, 2'd1, 2'd0), 4, 1'b1, 2'd3, 8'h01, 3'b000);
    run("sub_borrow", mk(3'b100, 2'd2, 2'd0, 2'd1), 4, 1'b1, 2'd2, 8'hFF, 3'b100);
    run("and", mk(3'b101, 2'd3, 2'd2, 2'd1), 4, 1'b1, 2'd3, 8'h01, 3'b000);
    run("not", mk(3'b110, 2'd3, 2'd0, 2'd0), 4, 1'b1, 2'd3, 8'hFF, 3'b100);
    run("movi_keep_flags", mki(2'd3, 8'h00), 2, 1'b1, 2'd3, 8'h00, 3'b100);
  endtask

  task automatic test_nop;
    run("nop", 16'h0000, 1, 1'b0, 2'd0, 8'h00, 3'b100);
  endtask

  task automatic test_reset_mid;
    in_valid = 1; in_instr = mk(3'b011, 2'd3, 2'd1, 2'd2);
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rmid we_exec got=%b exp=0", rf_we); end
    rst_n = 0;
    @(negedge clk);
    checks++; if ({rf_we, done, in_ready} !== 3'b0) begin errors++; $display("FAIL rmid outs got=%b exp=000", {rf_we, done, in_ready}); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL rmid flags got=%b exp=000", flags); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL rmid after got=%b%b exp=10", in_ready, rf_we); end
    checks++; if (mem[3] !== 8'h00) begin errors++; $display("FAIL rmid r3 got=%h exp=00", mem[3]); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] q [3];
    int idx = 0, dones = 0;
    logic acc;
    q[0] = mki(2'd0, 8'h11); q[1] = mki(2'd1, 8'h22); q[2] = mki(2'd2, 8'h33);
    in_valid = 1; in_instr = q[0];
    for (int c = 0; c < 15; c++) begin
      if (done) begin
        checks++;
        if (dones >= 3) begin errors++; $display("FAIL b2b extra_done got=%0d exp=3", dones + 1); end
        else if (rf_selA !== q[dones][12:11] || rf_dataW !== q[dones][7:0] || in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b write%0d got=%0d/%h/%b exp=%0d/%h/0", dones, rf_selA, rf_dataW, in_ready, q[dones][12:11], q[dones][7:0]);
        end
        dones++;
      end
      acc = in_ready && in_valid;
      @(negedge clk);
      if (acc) begin
        idx++;
        in_valid = idx < 3;
        in_instr = idx < 3 ? q[idx] : 16'h0000;
      end
    end
    checks++; if (dones !== 3) begin errors++; $display("FAIL b2b dones got=%0d exp=3", dones); end
    checks++; if (idx !== 3) begin errors++; $display("FAIL b2b accepts got=%0d exp=3", idx); end
    checks++; if (mem[0] !== 8'h11 || mem[1] !== 8'h22 || mem[2] !== 8'h33) begin errors++; $display("FAIL b2b regs got=%h %h %h exp=11 22 33", mem[0], mem[1], mem[2]); end
  endtask

  task automatic test_halt;
    in_valid = 1; in_instr = 16'hE000;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL halt ready_idle got=%b exp=1", in_ready); end
    @(negedge clk);
    in_instr = mki(2'd0, 8'h55);
    checks++; if ({in_ready, halted, done} !== 3'b000) begin errors++; $display("FAIL halt decode got=%b exp=000", {in_ready, halted, done}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({halted, in_ready, rf_we, done} !== 4'b1000) begin errors++; $display("FAIL halt hold%0d got=%b exp=1000", i, {halted, in_ready, rf_we, done}); end
    end
    checks++; if (mem[0] !== 8'h11) begin errors++; $display("FAIL halt r0 got=%h exp=11", mem[0]); end
    rst_n = 0;
    @(negedge clk);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt reset got=%b exp=0", halted); end
    rst_n = 1; in_valid = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL halt release got=%b%b exp=10", in_ready, halted); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_movi;
    test_add;
    test_alu;
    test_nop;
    test_reset_mid;
    test_back_to_back;
    test_halt;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
